// File: rtl/div_iter_if.sv
// div_iter_if: handshake and data bundle between the EX stage and the
// iterative divider.
//   master: drives start, cancel, flag_unsigned, operand1, operand2;
//           observes busy, done, div_by_zero, result.
//   slave : the divider itself (mirror image of master).
interface div_iter_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic                   cancel;
    logic                   flag_unsigned;
    logic [WIDTH-1:0]       operand1;
    logic [WIDTH-1:0]       operand2;
    logic                   busy;
    logic                   done;
    logic                   div_by_zero;
    logic [2*WIDTH-1:0]     result;

    modport master (
        output start, cancel, flag_unsigned, operand1, operand2,
        input  busy, done, div_by_zero, result
    );

    modport slave (
        input  start, cancel, flag_unsigned, operand1, operand2,
        output busy, done, div_by_zero, result
    );
endinterface

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider (DIV / DIVU) producing
// {remainder, quotient} for HI/LO writeback.
//   clock        : system clock, rising edge
//   reset        : synchronous, active-low
//   bus (slave)  : start/cancel/flag_unsigned/operand1/operand2 in,
//                  busy/done/div_by_zero/result out
// One quotient bit per cycle on magnitudes, then a single registered
// sign-correction cycle. Divide-by-zero skips the iterations entirely.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic    clock,
    input  logic    reset,
    div_iter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] ITER = CW'(WIDTH);

    state_t               state, next_state;
    logic [CW-1:0]        count;
    logic [WIDTH-1:0]     quo;       // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]     rem;       // partial remainder
    logic [WIDTH-1:0]     divisor;
    logic                 neg_q, neg_r, dz;
    logic [2*WIDTH-1:0]   result_q;
    logic                 dz_q;

    // Operand decode, only meaningful in the accept cycle.
    logic                 accept;
    logic                 sign1, sign2, op2_zero;
    logic [WIDTH-1:0]     abs1, abs2;

    assign accept   = (state == IDLE) && bus.start && !bus.cancel;
    assign sign1    = !bus.flag_unsigned && bus.operand1[WIDTH-1];
    assign sign2    = !bus.flag_unsigned && bus.operand2[WIDTH-1];
    // Negating the most negative value wraps to 2^(WIDTH-1), which is the
    // correct magnitude when read as unsigned.
    assign abs1     = sign1 ? -bus.operand1 : bus.operand1;
    assign abs2     = sign2 ? -bus.operand2 : bus.operand2;
    assign op2_zero = (bus.operand2 == '0);

    // One restoring step: shift the next dividend bit into the remainder and
    // compare on WIDTH+1 bits so the shifted-out remainder MSB is not lost.
    logic [WIDTH:0]       trial;
    logic                 fits;
    logic [WIDTH-1:0]     rem_sub;

    assign trial   = {rem, quo[WIDTH-1]};
    assign fits    = trial >= {1'b0, divisor};
    // The true difference is below divisor, so WIDTH bits hold it exactly.
    assign rem_sub = trial[WIDTH-1:0] - divisor;

    // NOTE: every sequential process uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: next_state gets its default before the case so no path through
    // this block leaves it unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (accept) next_state = op2_zero ? FIX : CALC;
            CALC: if (count == CW'(1)) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (bus.cancel) next_state = IDLE;
    end

    // Datapath. Nothing updates on a cancel cycle, so an aborted FIX never
    // disturbs the held result.
    // NOTE: the working registers are reset along with the outputs; they are
    // plain flops, not a memory, so the cost is trivial and sim never sees X.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count    <= '0;
            quo      <= '0;
            rem      <= '0;
            divisor  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            result_q <= '0;
            dz_q     <= 1'b0;
        end else if (!bus.cancel) begin
            unique case (state)
                IDLE: if (bus.start) begin
                    count   <= ITER;
                    // On divide-by-zero the raw dividend is kept, since it
                    // becomes the remainder unchanged.
                    quo     <= op2_zero ? bus.operand1 : abs1;
                    rem     <= '0;
                    divisor <= abs2;
                    neg_q   <= sign1 ^ sign2;
                    neg_r   <= sign1;
                    dz      <= op2_zero;
                end
                CALC: begin
                    count <= count - CW'(1);
                    rem   <= fits ? rem_sub : trial[WIDTH-1:0];
                    quo   <= {quo[WIDTH-2:0], fits};
                end
                FIX: begin
                    if (dz)
                        result_q <= {quo, {WIDTH{1'b1}}};
                    else
                        result_q <= {neg_r ? -rem : rem, neg_q ? -quo : quo};
                    dz_q <= dz;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state == CALC) || (state == FIX);
    assign bus.done        = (state == DONE);
    assign bus.div_by_zero = dz_q;
    assign bus.result      = result_q;
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed self-checking bench for div_iter (WIDTH=32).
module tb_div_iter;
    localparam int W = 32;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   fails  = 0;

    div_iter_if #(.WIDTH(W)) bus ();

    div_iter #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " busy"},   64'(bus.busy),        64'd0);
        check({tag, " done"},   64'(bus.done),        64'd0);
        check({tag, " dz"},     64'(bus.div_by_zero), 64'd0);
        check({tag, " result"}, bus.result,           64'd0);
    endtask

    // Drives start between edge 0 and edge 1; the start is accepted at edge 1.
    // Returns after the cycle following done.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic uns, input logic [63:0] exp_res,
                           input logic exp_dz, input int exp_lat);
        int lat = -1;
        @(negedge clock);
        bus.start = 1'b1;
        bus.operand1 = a;
        bus.operand2 = b;
        bus.flag_unsigned = uns;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(posedge clock); #1;
            if (cyc == 1) begin
                bus.start = 1'b0;
                // Scramble inputs: only the latched copies may matter now.
                bus.operand1 = $urandom;
                bus.operand2 = $urandom;
                bus.flag_unsigned = ~uns;
                check({tag, " busy after accept"}, 64'(bus.busy), 64'd1);
            end
            if (bus.done) begin
                lat = cyc;
                break;
            end
        end
        check({tag, " done edge"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, bus.result, exp_res);
        check({tag, " dz"}, 64'(bus.div_by_zero), 64'(exp_dz));
        @(posedge clock); #1;
        check({tag, " done one cycle"}, 64'(bus.done), 64'd0);
        check({tag, " result held"}, bus.result, exp_res);
    endtask

    initial begin
        int ndone;
        int t1, t2;
        bus.start = 1'b0;
        bus.cancel = 1'b0;
        bus.flag_unsigned = 1'b0;
        bus.operand1 = '0;
        bus.operand2 = '0;

        repeat (2) @(posedge clock);
        #1;
        check_zero_outputs("reset");
        reset = 1'b1;

        // Normal and signed cases.
        run_div("u100/7", 32'd100, 32'd7, 1'b1, {32'd2, 32'd14}, 1'b0, W + 2);
        run_div("s-7/2", 32'hFFFF_FFF9, 32'd2, 1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, W + 2);
        run_div("s7/-2", 32'd7, 32'hFFFF_FFFE, 1'b0, {32'h0000_0001, 32'hFFFF_FFFD}, 1'b0, W + 2);
        run_div("sMIN/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h0, 32'h8000_0000}, 1'b0, W + 2);
        run_div("uMIN/max", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h8000_0000, 32'h0}, 1'b0, W + 2);

        // Divide by zero, then a normal divide clears the flag.
        run_div("s5/0", 32'd5, 32'd0, 1'b0, {32'd5, 32'hFFFF_FFFF}, 1'b1, 2);
        run_div("u20/3", 32'd20, 32'd3, 1'b1, {32'd2, 32'd6}, 1'b0, W + 2);

        // Cancel sampled at edge 11 of an operation accepted at edge 1.
        @(negedge clock);
        bus.start = 1'b1;
        bus.operand1 = 32'd1000;
        bus.operand2 = 32'd10;
        bus.flag_unsigned = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clock); #1;
            if (cyc == 1) bus.start = 1'b0;
        end
        bus.cancel = 1'b1;
        @(posedge clock); #1;
        bus.cancel = 1'b0;
        check("cancel busy", 64'(bus.busy), 64'd0);
        check("cancel result kept", bus.result, {32'd2, 32'd6});
        check("cancel dz kept", 64'(bus.div_by_zero), 64'd0);
        ndone = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clock); #1;
            if (bus.done) ndone++;
        end
        check("cancel no done", 64'(ndone), 64'd0);

        run_div("u1000/10", 32'd1000, 32'd10, 1'b1, {32'd0, 32'd100}, 1'b0, W + 2);

        // Reset sampled at edge 20 of an operation.
        @(negedge clock);
        bus.start = 1'b1;
        bus.operand1 = 32'd50;
        bus.operand2 = 32'd5;
        bus.flag_unsigned = 1'b1;
        for (int cyc = 1; cyc <= 19; cyc++) begin
            @(posedge clock); #1;
            if (cyc == 1) bus.start = 1'b0;
        end
        reset = 1'b0;
        @(posedge clock); #1;
        check_zero_outputs("midop reset");
        reset = 1'b1;

        // start held high: accepts at edges 1, 36, 71 -> done after 34, 69, 104.
        @(negedge clock);
        bus.start = 1'b1;
        bus.operand1 = 32'd9;
        bus.operand2 = 32'd4;
        bus.flag_unsigned = 1'b1;
        ndone = 0;
        t1 = -1;
        t2 = -1;
        for (int cyc = 1; cyc <= 105; cyc++) begin
            @(posedge clock); #1;
            if (bus.done) begin
                ndone++;
                if (ndone == 1) t1 = cyc;
                if (ndone == 2) t2 = cyc;
            end
            if (cyc == W + 3) check("held idle gap busy", 64'(bus.busy), 64'd0);
        end
        bus.start = 1'b0;
        check("held done count", 64'(ndone), 64'd3);
        check("held first done", 64'(t1), 64'(W + 2));
        check("held second done", 64'(t2), 64'(2 * W + 5));
        check("held result", bus.result, {32'd1, 32'd2});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
